// File: rtl/hack_bus_arbiter_pkg.sv
// Shared constants and output-stage state type for the round-robin bus arbiter.
package hack_bus_arbiter_pkg;
  localparam int NUM_REQ = 8;
  localparam int DATA_W  = 16;
  localparam int SRC_W   = 3;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;
endpackage

// File: rtl/mux_8x1_16bits.sv
// 8:1 word selector; data_in[k] appears on data_out when sel_in == k.
module mux_8x1_16bits
  import hack_bus_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0][DATA_W-1:0] data_in,
  input  logic [SRC_W-1:0]               sel_in,
  output logic [DATA_W-1:0]              data_out
);
  assign data_out = data_in[sel_in];
endmodule

// File: rtl/hack_bus_arbiter.sv
// Round-robin arbiter feeding a single-entry output register with a handshake counter.
module hack_bus_arbiter
  import hack_bus_arbiter_pkg::*;
(
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic [NUM_REQ-1:0]             req_valid_in,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_data_in,
  output logic [NUM_REQ-1:0]             req_ready_out,
  output logic                           out_valid_out,
  output logic [DATA_W-1:0]              out_data_out,
  output logic [SRC_W-1:0]               out_src_out,
  input  logic                           out_ready_in,
  output logic [15:0]                    xfer_count_out
);
  state_e             state_q, state_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [SRC_W-1:0]   src_q, src_d;
  logic [SRC_W-1:0]   ptr_q, ptr_d;
  logic [15:0]        count_q, count_d;

  logic               slot_free;
  logic               win_found;
  logic [SRC_W-1:0]   win_idx;
  logic [SRC_W-1:0]   cand;
  logic               grant;
  logic [DATA_W-1:0]  mux_out;

  assign slot_free = (state_q == ST_EMPTY) || out_ready_in;

  // First valid requester at or after ptr; the 3-bit add supplies the mod-8 wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ptr_q + SRC_W'(k);
      if (!win_found && req_valid_in[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Reset gating keeps the accept strobe quiet while the block is held in reset.
  assign grant         = slot_free && win_found && !rst_in;
  assign req_ready_out = grant ? (NUM_REQ'(1) << win_idx) : '0;

  mux_8x1_16bits u_data_mux (
    .data_in  (req_data_in),
    .sel_in   (win_idx),
    .data_out (mux_out)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    src_d   = src_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    if (state_q == ST_FULL && out_ready_in) begin
      count_d = count_q + 16'd1;
    end
    if (grant) begin
      state_d = ST_FULL;
      data_d  = mux_out;
      src_d   = win_idx;
      ptr_d   = win_idx + 3'd1;
    end else if (slot_free) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      src_q   <= '0;
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  assign out_valid_out  = (state_q == ST_FULL);
  assign out_data_out   = data_q;
  assign out_src_out    = src_q;
  assign xfer_count_out = count_q;
endmodule

// File: tb/tb_hack_bus_arbiter.sv
// Directed and random stimulus against a round-robin reference model of the arbiter.
module tb_hack_bus_arbiter;
  logic             clk;
  logic             rst_in;
  logic [7:0]       req_valid_in;
  logic [7:0][15:0] req_data_in;
  logic [7:0]       req_ready_out;
  logic             out_valid_out;
  logic [15:0]      out_data_out;
  logic [2:0]       out_src_out;
  logic             out_ready_in;
  logic [15:0]      xfer_count_out;

  hack_bus_arbiter dut (
    .clk_in         (clk),
    .rst_in         (rst_in),
    .req_valid_in   (req_valid_in),
    .req_data_in    (req_data_in),
    .req_ready_out  (req_ready_out),
    .out_valid_out  (out_valid_out),
    .out_data_out   (out_data_out),
    .out_src_out    (out_src_out),
    .out_ready_in   (out_ready_in),
    .xfer_count_out (xfer_count_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b1;

  // Reference model state
  bit          m_valid;
  logic [15:0] m_data;
  int          m_src;
  int          m_ptr;
  logic [15:0] m_count;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = 16'h0000;
    m_src   = 0;
    m_ptr   = 0;
    m_count = 16'h0000;
  endtask

  // One clock: check the accept strobe at negedge, then registered outputs after the edge.
  task automatic step();
    int          win;
    bit          free;
    logic [7:0]  exp_ready;
    logic [15:0] win_data;
    bit          rdy;
    @(negedge clk);
    free = !m_valid || out_ready_in;
    rdy  = out_ready_in;
    win  = -1;
    for (int k = 0; k < 8; k++) begin
      if (win < 0 && req_valid_in[(m_ptr + k) % 8]) win = (m_ptr + k) % 8;
    end
    exp_ready = (free && win >= 0) ? (8'd1 << win) : 8'd0;
    win_data  = (win >= 0) ? req_data_in[win] : 16'h0000;
    if (check_en) chk("req_ready", {24'd0, req_ready_out}, {24'd0, exp_ready});
    @(posedge clk);
    #1;
    if (m_valid && rdy) m_count = m_count + 16'd1;
    if (free && win >= 0) begin
      m_valid = 1'b1;
      m_data  = win_data;
      m_src   = win;
      m_ptr   = (win + 1) % 8;
    end else if (free) begin
      m_valid = 1'b0;
    end
    if (check_en) begin
      chk("out_valid", {31'd0, out_valid_out}, {31'd0, m_valid});
      if (m_valid) begin
        chk("out_data", {16'd0, out_data_out}, {16'd0, m_data});
        chk("out_src", {29'd0, out_src_out}, m_src);
      end
      chk("xfer_count", {16'd0, xfer_count_out}, {16'd0, m_count});
    end
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    @(posedge clk);
    #1;
    rst_in = 1'b0;
    model_reset();
  endtask

  task automatic rand_data();
    for (int i = 0; i < 8; i++) req_data_in[i] = 16'($urandom);
  endtask

  initial begin
    logic [15:0] held_data;
    logic [2:0]  held_src;
    int          guard;

    rst_in       = 1'b1;
    req_valid_in = 8'hFF;
    out_ready_in = 1'b1;
    rand_data();
    model_reset();

    // Reset state, with every requester asking
    #2;
    chk("rst_ready", {24'd0, req_ready_out}, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, out_valid_out}, 32'd0);
    chk("rst_data", {16'd0, out_data_out}, 32'd0);
    chk("rst_src", {29'd0, out_src_out}, 32'd0);
    chk("rst_count", {16'd0, xfer_count_out}, 32'd0);
    rst_in = 1'b0;
    req_valid_in = 8'h00;

    // Distinct data per requester, each alone: select ordering and 1-cycle latency
    for (int i = 0; i < 8; i++) req_data_in[i] = 16'h1000 + 16'(i);
    for (int i = 0; i < 8; i++) begin
      req_valid_in = 8'd1 << i;
      step();
      chk("alone_data", {16'd0, out_data_out}, 32'h1000 + i);
      chk("alone_src", {29'd0, out_src_out}, i);
      chk("alone_valid", {31'd0, out_valid_out}, 32'd1);
    end

    // All valid from reset: 0..7 then 0, one word per cycle
    do_reset();
    req_valid_in = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      rand_data();
      step();
      chk("rr_src", {29'd0, out_src_out}, i % 8);
    end

    // Pointer at 6, requesters 2 and 6: 6, 2, 6
    req_valid_in = 8'b0010_0000;
    step();
    req_valid_in = 8'b0100_0100;
    step();
    chk("wrap_src0", {29'd0, out_src_out}, 32'd6);
    step();
    chk("wrap_src1", {29'd0, out_src_out}, 32'd2);
    step();
    chk("wrap_src2", {29'd0, out_src_out}, 32'd6);

    // Backpressure while FULL with requester 3 waiting
    req_valid_in = 8'b0000_1000;
    rand_data();
    step();
    held_data = out_data_out;
    held_src  = out_src_out;
    out_ready_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rand_data();
      step();
      chk("hold_data", {16'd0, out_data_out}, {16'd0, held_data});
      chk("hold_src", {29'd0, out_src_out}, {29'd0, held_src});
    end
    out_ready_in = 1'b1;
    step();
    chk("release_src", {29'd0, out_src_out}, 32'd3);

    // Counter wrap: preload to FFFE by traffic, then three handshakes
    do_reset();
    req_valid_in = 8'hFF;
    out_ready_in = 1'b1;
    check_en = 1'b0;
    guard = 0;
    while (m_count != 16'hFFFE && guard < 70000) begin
      step();
      guard++;
    end
    check_en = 1'b1;
    chk("preload_count", {16'd0, xfer_count_out}, 32'hFFFE);
    step();
    chk("count_ffff", {16'd0, xfer_count_out}, 32'hFFFF);
    step();
    chk("count_0000", {16'd0, xfer_count_out}, 32'h0000);
    step();
    chk("count_0001", {16'd0, xfer_count_out}, 32'h0001);

    // Random traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      req_valid_in = 8'($urandom);
      out_ready_in = 1'($urandom);
      rand_data();
      step();
    end

    // Asynchronous reset mid-cycle while FULL
    req_valid_in = 8'hFF;
    out_ready_in = 1'b0;
    step();
    chk("pre_async_valid", {31'd0, out_valid_out}, 32'd1);
    #2;
    rst_in = 1'b1;
    #1;
    chk("async_valid", {31'd0, out_valid_out}, 32'd0);
    chk("async_ready", {24'd0, req_ready_out}, 32'd0);
    chk("async_count", {16'd0, xfer_count_out}, 32'd0);
    @(posedge clk);
    #1;
    rst_in = 1'b0;
    model_reset();
    req_valid_in = 8'b0110_1000;
    out_ready_in = 1'b1;
    step();
    chk("post_rst_src", {29'd0, out_src_out}, 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hack_bus_arbiter.md
HACK_BUS_ARBITER -- requirements
Module: hack_bus_arbiter

Interface
REQ-001 Parameters: none; requester count is fixed at 8 and data width at 16 (package constants).
REQ-002 clk_in  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_in  input  1  reset, asynchronous, active-high.
REQ-004 req_valid_in  input  [7:0]  per-requester word-valid.
REQ-005 req_data_in  input  [7:0][15:0]  per-requester 16-bit word.
REQ-006 req_ready_out  output  [7:0]  one-hot-or-zero accept strobe.
REQ-007 out_valid_out  output  1  output register holds a word.
REQ-008 out_data_out  output  16  registered word.
REQ-009 out_src_out  output  3  index of the requester that supplied out_data_out.
REQ-010 out_ready_in  input  1  downstream accept.
REQ-011 xfer_count_out  output  16  count of completed output handshakes.

Function
REQ-012 Output stage SHALL be one register with two states: EMPTY (out_valid_out=0) and FULL (out_valid_out=1).
REQ-013 Slot is "free" in a cycle when EMPTY, or when FULL and out_ready_in=1.
REQ-014 When the slot is free and any req_valid_in bit is set, the block SHALL pick exactly one winner and assert only that bit of req_ready_out, combinationally, in the same cycle.
REQ-015 When the slot is not free, or no requester is valid, req_ready_out SHALL be 8'h00.
REQ-016 Winner SHALL be the first valid index found searching ptr, ptr+1, ..., ptr+7, all mod 8.
REQ-017 After a grant to index i, ptr SHALL become (i+1) mod 8, wrapping 7 to 0; with no grant, ptr SHALL hold.
REQ-018 On a grant, at the next edge: out_data_out = req_data_in[i], out_src_out = i, state FULL; latency is 1 cycle from acceptance to out_valid_out.
REQ-019 Data SHALL be routed through the internal 8:1 16-bit mux, with its select derived from i so that the mux output equals req_data_in[i] for every i in 0..7 (mux select bit ordering accounted for in the select wiring).
REQ-020 FULL with out_ready_in=1 and a grant in the same cycle SHALL reload the register, staying FULL: one word per cycle sustained.
REQ-021 FULL with out_ready_in=1 and no grant SHALL go to EMPTY.
REQ-022 FULL with out_ready_in=0 SHALL hold out_data_out, out_src_out and out_valid_out stable.
REQ-023 out_ready_in while EMPTY SHALL be ignored and SHALL NOT count.
REQ-024 xfer_count_out SHALL increment by 1 per cycle with out_valid_out=1 and out_ready_in=1, wrapping 16'hFFFF to 16'h0000.
REQ-025 A requester holding req_valid_in high SHALL be granted within 8 grants (no starvation).
REQ-026 The only combinational paths to outputs SHALL be req_valid_in/out_ready_in to req_ready_out.

Reset
REQ-027 While rst_in=1: out_valid_out=0, out_data_out=16'h0000, out_src_out=3'd0, ptr=3'd0, xfer_count_out=16'h0000, state EMPTY, req_ready_out=8'h00.
REQ-028 Reset asserted mid-transfer SHALL discard the held word immediately; the first grant after release SHALL use ptr=0.

Structure
REQ-029 Shared package SHALL hold NUM_REQ=8, DATA_W=16, SRC_W=3, and the EMPTY/FULL state enum.
REQ-030 One sub-module: mux_8x1_16bits instance (data select); arbitration, pointer, register and counter live in the top.

Verification
REQ-031 Distinct data 16'h1000+i on all 8 requesters, each valid alone in turn, out_ready_in=1 -> out_data_out=16'h1000+i, out_src_out=i, 1-cycle latency (catches select-order wiring errors).
REQ-032 All 8 valid continuously, out_ready_in=1, from reset -> grant order 0,1,...,7,0, one word per cycle, req_ready_out one-hot each cycle.
REQ-033 ptr=6, valid only on 2 and 6 -> grants 6, then 2, then 6 (wrap 7 to 0 checked).
REQ-034 out_ready_in=0 for 5 cycles while FULL with requester 3 valid -> outputs stable, req_ready_out=8'h00, then drains and grants 3 in the release cycle.
REQ-035 Preload xfer_count_out to 16'hFFFE by traffic, 3 handshakes -> 16'hFFFF, 16'h0000, 16'h0001.
REQ-036 rst_in pulsed mid-stream while FULL -> out_valid_out falls without waiting for a clock edge; next grant after release goes to lowest valid index.
